// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P request/response header definitions used by the SPL-style memory responder.
package ccip_if_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

endpackage

// File: rtl/spl_mem_rsp_pkg.sv
// Shared types and response-header defaults for the SPL memory responder.
package spl_mem_rsp_pkg;
    import ccip_if_pkg::*;

    // One buffered read response: line data plus the echoed request tag.
    typedef struct packed {
        logic [511:0] data;
        logic [15:0]  mdata;
    } t_rd_entry;

    localparam int RD_ENTRY_BITS = $bits(t_rd_entry);

    localparam t_ccip_vc     RSP_VC          = eVC_VL0;
    localparam t_ccip_c0_rsp RD_RSP_TYPE     = eRSP_RDLINE;
    localparam t_ccip_c1_rsp WR_RSP_TYPE     = eRSP_WRLINE;
    localparam t_ccip_c1_rsp FENCE_RSP_TYPE  = eRSP_WRFENCE;

    function automatic t_ccip_c0_RspMemHdr rd_rsp_hdr(input logic [15:0] mdata);
        t_ccip_c0_RspMemHdr h;
        h           = '0;
        h.vc_used   = RSP_VC;
        h.resp_type = RD_RSP_TYPE;
        h.mdata     = mdata;
        return h;
    endfunction

    function automatic t_ccip_c1_RspMemHdr wr_rsp_hdr(input t_ccip_c1_rsp rtype,
                                                      input logic [15:0] mdata);
        t_ccip_c1_RspMemHdr h;
        h           = '0;
        h.vc_used   = RSP_VC;
        h.resp_type = rtype;
        h.mdata     = mdata;
        return h;
    endfunction

endpackage

// File: rtl/spl_rsp_fifo.sv
// Synchronous FIFO with first-word-visible read port, used to buffer read responses.
module spl_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy update; a push at full is accepted only alongside a pop.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        count    = count_q;
        pop_data = mem_q[rd_ptr_q];
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spl_mem_responder.sv
// Host-memory endpoint for the SPL AFU read/write channels, backed by a line-wide RAM.
module spl_mem_responder
    import ccip_if_pkg::*;
    import spl_mem_rsp_pkg::*;
#(
    parameter int ADDR_BITS     = 10,
    parameter int FIFO_DEPTH    = 16,
    parameter int ALMFULL_SLACK = 4,
    parameter int RSP_INTERVAL  = 1
) (
    input  logic               clk,
    input  logic               spl_reset,
    input  logic               afu_tx_rd_valid,
    input  t_ccip_c0_ReqMemHdr afu_tx_rd_hdr,
    input  logic               afu_tx_wr_valid,
    input  t_ccip_c1_ReqMemHdr afu_tx_wr_hdr,
    input  logic [511:0]       afu_tx_data,
    output logic               spl_tx_rd_almostfull,
    output logic               spl_tx_wr_almostfull,
    output logic               spl_rx_rd_valid,
    output t_ccip_c0_RspMemHdr spl_rx_rd_hdr,
    output logic [511:0]       spl_rx_data,
    output logic               spl_rx_wr_valid,
    output t_ccip_c1_RspMemHdr spl_rx_wr_hdr,
    output logic               err_rd_overflow,
    output logic [31:0]        stat_rd_cnt,
    output logic [31:0]        stat_wr_cnt
);
    localparam int RAM_LINES = 1 << ADDR_BITS;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int PACE_W    = (RSP_INTERVAL > 1) ? $clog2(RSP_INTERVAL) : 1;
    localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(RSP_INTERVAL - 1);
    localparam logic [CNT_W-1:0]  OCC_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  OCC_AFULL = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);

    logic [511:0] ram_q [RAM_LINES];

    logic [ADDR_BITS-1:0] rd_idx, wr_idx;
    logic                 wr_line, wr_fence;

    // Staging slot: the request accepted last cycle whose RAM data is now in rd_data_q.
    logic          stg_valid_q, stg_valid_d;
    logic [15:0]   stg_mdata_q, stg_mdata_d;
    logic [511:0]  rd_data_q, rd_data_d;

    logic [PACE_W-1:0] pace_q, pace_d;

    logic               rd_valid_q, rd_valid_d;
    t_ccip_c0_RspMemHdr rd_hdr_q, rd_hdr_d;
    logic [511:0]       rx_data_q, rx_data_d;
    logic               wr_valid_q, wr_valid_d;
    t_ccip_c1_RspMemHdr wr_hdr_q, wr_hdr_d;
    logic               almfull_q, almfull_d;
    logic               err_q, err_d;
    logic [31:0]        rd_cnt_q, rd_cnt_d;
    logic [31:0]        wr_cnt_q, wr_cnt_d;

    t_rd_entry        stg_entry, fifo_head, head_entry;
    logic [CNT_W-1:0] fifo_count, occ;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic             emit, bypass, rd_drop, rd_accept;

    assign rd_idx   = afu_tx_rd_hdr.address[ADDR_BITS-1:0];
    assign wr_idx   = afu_tx_wr_hdr.address[ADDR_BITS-1:0];
    assign wr_line  = afu_tx_wr_valid && ((afu_tx_wr_hdr.req_type == eREQ_WRLINE_I) ||
                                          (afu_tx_wr_hdr.req_type == eREQ_WRLINE_M));
    assign wr_fence = afu_tx_wr_valid && (afu_tx_wr_hdr.req_type == eREQ_WRFENCE);

    // Header bits this endpoint does not interpret (vc, cl_len, upper address, reserved).
    logic unused_bits;
    assign unused_bits = ^{afu_tx_rd_hdr, afu_tx_wr_hdr, fifo_full};

    spl_rsp_fifo #(
        .WIDTH (RD_ENTRY_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (spl_reset),
        .push      (fifo_push),
        .push_data (stg_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Read path: accept/drop decision, pacing, and selection of the next response.
    // With the FIFO empty the staged entry is emitted directly so an idle responder
    // answers at T+2; otherwise the staged entry queues behind older responses.
    always_comb begin
        stg_entry.data  = rd_data_q;
        stg_entry.mdata = stg_mdata_q;
        occ        = fifo_count + CNT_W'(stg_valid_q);
        emit       = (pace_q == '0) && (stg_valid_q || !fifo_empty);
        bypass     = emit && fifo_empty;
        fifo_pop   = emit && !fifo_empty;
        fifo_push  = stg_valid_q && !bypass;
        head_entry = fifo_empty ? stg_entry : fifo_head;
        rd_drop    = afu_tx_rd_valid && (occ == OCC_FULL) && !emit;
        rd_accept  = afu_tx_rd_valid && !rd_drop;

        stg_valid_d = rd_accept;
        stg_mdata_d = afu_tx_rd_hdr.mdata;
        rd_data_d   = ram_q[rd_idx];

        if (emit) begin
            pace_d = PACE_LOAD;
        end else if (pace_q != '0) begin
            pace_d = pace_q - PACE_W'(1);
        end else begin
            pace_d = '0;
        end

        rd_valid_d = emit;
        rd_hdr_d   = emit ? rd_rsp_hdr(head_entry.mdata) : '0;
        rx_data_d  = emit ? head_entry.data : '0;

        almfull_d = (occ >= OCC_AFULL);
        err_d     = err_q || rd_drop;
        rd_cnt_d  = rd_accept ? rd_cnt_q + 32'd1 : rd_cnt_q;
    end

    // Write path: one-cycle response for line writes and fences.
    always_comb begin
        wr_valid_d = wr_line || wr_fence;
        if (wr_line) begin
            wr_hdr_d = wr_rsp_hdr(WR_RSP_TYPE, afu_tx_wr_hdr.mdata);
        end else if (wr_fence) begin
            wr_hdr_d = wr_rsp_hdr(FENCE_RSP_TYPE, afu_tx_wr_hdr.mdata);
        end else begin
            wr_hdr_d = '0;
        end
        wr_cnt_d = wr_valid_d ? wr_cnt_q + 32'd1 : wr_cnt_q;
    end

    // Line RAM: read and write share the cycle; the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_line) begin
            ram_q[wr_idx] <= afu_tx_data;
        end
        rd_data_q <= rd_data_d;
    end

    // Control, staging and output registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (spl_reset) begin
            stg_valid_q <= 1'b0;
            stg_mdata_q <= '0;
            pace_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_hdr_q    <= '0;
            rx_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_hdr_q    <= '0;
            almfull_q   <= 1'b0;
            err_q       <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_mdata_q <= stg_mdata_d;
            pace_q      <= pace_d;
            rd_valid_q  <= rd_valid_d;
            rd_hdr_q    <= rd_hdr_d;
            rx_data_q   <= rx_data_d;
            wr_valid_q  <= wr_valid_d;
            wr_hdr_q    <= wr_hdr_d;
            almfull_q   <= almfull_d;
            err_q       <= err_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign spl_tx_rd_almostfull = almfull_q;
    assign spl_tx_wr_almostfull = 1'b0;
    assign spl_rx_rd_valid      = rd_valid_q;
    assign spl_rx_rd_hdr        = rd_hdr_q;
    assign spl_rx_data          = rx_data_q;
    assign spl_rx_wr_valid      = wr_valid_q;
    assign spl_rx_wr_hdr        = wr_hdr_q;
    assign err_rd_overflow      = err_q;
    assign stat_rd_cnt          = rd_cnt_q;
    assign stat_wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_spl_mem_responder.sv
// Directed bench for spl_mem_responder: three instances (interval 1, 4, 8) share stimulus.
module tb_spl_mem_responder;
    import ccip_if_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               spl_reset;
    logic               afu_tx_rd_valid;
    t_ccip_c0_ReqMemHdr afu_tx_rd_hdr;
    logic               afu_tx_wr_valid;
    t_ccip_c1_ReqMemHdr afu_tx_wr_hdr;
    logic [511:0]       afu_tx_data;

    logic               rd_afull [3];
    logic               wr_afull [3];
    logic               rd_valid [3];
    t_ccip_c0_RspMemHdr rd_hdr   [3];
    logic [511:0]       rx_data  [3];
    logic               wr_valid [3];
    t_ccip_c1_RspMemHdr wr_hdr   [3];
    logic               err      [3];
    logic [31:0]        rd_cnt   [3];
    logic [31:0]        wr_cnt   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spl_mem_responder #(
            .ADDR_BITS     (10),
            .FIFO_DEPTH    (16),
            .ALMFULL_SLACK (4),
            .RSP_INTERVAL  (g == 0 ? 1 : (g == 1 ? 4 : 8))
        ) u_dut (
            .clk                  (clk),
            .spl_reset            (spl_reset),
            .afu_tx_rd_valid      (afu_tx_rd_valid),
            .afu_tx_rd_hdr        (afu_tx_rd_hdr),
            .afu_tx_wr_valid      (afu_tx_wr_valid),
            .afu_tx_wr_hdr        (afu_tx_wr_hdr),
            .afu_tx_data          (afu_tx_data),
            .spl_tx_rd_almostfull (rd_afull[g]),
            .spl_tx_wr_almostfull (wr_afull[g]),
            .spl_rx_rd_valid      (rd_valid[g]),
            .spl_rx_rd_hdr        (rd_hdr[g]),
            .spl_rx_data          (rx_data[g]),
            .spl_rx_wr_valid      (wr_valid[g]),
            .spl_rx_wr_hdr        (wr_hdr[g]),
            .err_rd_overflow      (err[g]),
            .stat_rd_cnt          (rd_cnt[g]),
            .stat_wr_cnt          (wr_cnt[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-response monitor: ring of the last 64 responses per instance.
    logic [15:0] mon_md  [3][64];
    logic [7:0]  mon_b   [3][64];
    int          mon_cyc [3][64];
    int          mon_n   [3] = '{0, 0, 0};
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_valid[i]) begin
                mon_md[i][mon_n[i] % 64]  <= rd_hdr[i].mdata;
                mon_b[i][mon_n[i] % 64]   <= rx_data[i][7:0];
                mon_cyc[i][mon_n[i] % 64] <= cyc;
                mon_n[i]                  <= mon_n[i] + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_req();
        afu_tx_rd_valid = 1'b0;
        afu_tx_rd_hdr   = '0;
        afu_tx_wr_valid = 1'b0;
        afu_tx_wr_hdr   = '0;
        afu_tx_data     = '0;
    endtask

    task automatic set_rd(input logic [41:0] a, input logic [15:0] md);
        afu_tx_rd_valid         = 1'b1;
        afu_tx_rd_hdr           = '0;
        afu_tx_rd_hdr.req_type  = eREQ_RDLINE_I;
        afu_tx_rd_hdr.address   = a;
        afu_tx_rd_hdr.mdata     = md;
    endtask

    task automatic set_wr(input t_ccip_c1_req t, input logic [41:0] a,
                          input logic [15:0] md, input logic [7:0] b);
        afu_tx_wr_valid        = 1'b1;
        afu_tx_wr_hdr          = '0;
        afu_tx_wr_hdr.req_type = t;
        afu_tx_wr_hdr.address  = a;
        afu_tx_wr_hdr.mdata    = md;
        afu_tx_data            = {64{b}};
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_req();
        spl_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        spl_reset = 1'b0;
    endtask

    function automatic t_ccip_c0_RspMemHdr exp_rd_hdr(input logic [15:0] md);
        t_ccip_c0_RspMemHdr h;
        h           = '0;
        h.resp_type = eRSP_RDLINE;
        h.vc_used   = eVC_VL0;
        h.mdata     = md;
        return h;
    endfunction

    // op: 0 read, 1 WRLINE_I, 2 WRLINE_M, 3 WRFENCE
    typedef struct {
        int          op;
        logic [41:0] addr;
        logic [15:0] md;
        logic [7:0]  wbyte;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vt [9];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        int base [3];
        int afull_seen;
        t_ccip_c1_rsp exp_wtype;

        vt[0] = '{1, 42'd5,     16'h0011, 8'hA5, 8'h00};
        vt[1] = '{0, 42'd5,     16'h0022, 8'h00, 8'hA5};
        vt[2] = '{1, 42'h405,   16'h0012, 8'h3C, 8'h00};
        vt[3] = '{0, 42'd5,     16'h0023, 8'h00, 8'h3C};
        vt[4] = '{1, 42'd3,     16'h0013, 8'h00, 8'h00};
        vt[5] = '{3, 42'd5,     16'h0007, 8'h00, 8'h00};
        vt[6] = '{0, 42'd5,     16'h0024, 8'h00, 8'h3C};
        vt[7] = '{2, 42'd7,     16'h0014, 8'h5A, 8'h00};
        vt[8] = '{0, 42'd7,     16'h0025, 8'h00, 8'h5A};

        clr_req();
        spl_reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valids", 512'({rd_valid[0], wr_valid[0], rd_afull[0], wr_afull[0], err[0]}), 512'(0));
        chk("reset_cnts", 512'({rd_cnt[0], wr_cnt[0]}), 512'(0));
        chk("reset_rd_hdr", 512'(rd_hdr[0]), 512'(0));
        spl_reset = 1'b0;
        @(negedge clk);

        // Table-driven single requests against the interval-1 instance.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            case (vt[i].op)
                0: set_rd(vt[i].addr, vt[i].md);
                1: set_wr(eREQ_WRLINE_I, vt[i].addr, vt[i].md, vt[i].wbyte);
                2: set_wr(eREQ_WRLINE_M, vt[i].addr, vt[i].md, vt[i].wbyte);
                default: set_wr(eREQ_WRFENCE, vt[i].addr, vt[i].md, vt[i].wbyte);
            endcase
            @(negedge clk);
            clr_req();
            if (vt[i].op == 0) begin
                chk($sformatf("v%0d_rd_not_early", i), 512'(rd_valid[0]), 512'(0));
            end else begin
                exp_wtype = (vt[i].op == 3) ? eRSP_WRFENCE : eRSP_WRLINE;
                chk($sformatf("v%0d_wr_valid", i), 512'(wr_valid[0]), 512'(1));
                chk($sformatf("v%0d_wr_hdr", i),
                    512'({wr_hdr[0].resp_type, wr_hdr[0].mdata, wr_hdr[0].format}),
                    512'({exp_wtype, vt[i].md, 1'b0}));
            end
            @(negedge clk);
            if (vt[i].op == 0) begin
                chk($sformatf("v%0d_rd_valid", i), 512'(rd_valid[0]), 512'(1));
                chk($sformatf("v%0d_rd_hdr", i), 512'(rd_hdr[0]), 512'(exp_rd_hdr(vt[i].md)));
                chk($sformatf("v%0d_rd_data", i), rx_data[0], {64{vt[i].exp_byte}});
            end else begin
                chk($sformatf("v%0d_wr_one_cycle", i), 512'(wr_valid[0]), 512'(0));
            end
        end
        chk("tbl_stat_wr", 512'(wr_cnt[0]), 512'(5));
        chk("tbl_stat_rd", 512'(rd_cnt[0]), 512'(4));

        // Same-cycle write and read to line 3: old data first, new data one cycle later.
        @(negedge clk);
        set_wr(eREQ_WRLINE_I, 42'd3, 16'h0015, 8'hFF);
        set_rd(42'd3, 16'h0033);
        @(negedge clk);
        afu_tx_wr_valid = 1'b0;
        set_rd(42'd3, 16'h0034);
        @(negedge clk);
        clr_req();
        chk("rbw_old_valid", 512'(rd_valid[0]), 512'(1));
        chk("rbw_old_md", 512'(rd_hdr[0].mdata), 512'(16'h0033));
        chk("rbw_old_data", rx_data[0], {64{8'h00}});
        @(negedge clk);
        chk("rbw_new_md", 512'(rd_hdr[0].mdata), 512'(16'h0034));
        chk("rbw_new_data", rx_data[0], {64{8'hFF}});

        // Pacing: 8 back-to-back reads, interval-4 instance spaces them 4 apart.
        do_reset();
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) base[i] = mon_n[i];
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin
            set_rd(42'd7, 16'h0040 + 16'(k));
            @(negedge clk);
        end
        clr_req();
        afull_seen = 0;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (rd_afull[1]) afull_seen = 1;
        end
        #1;
        chk("pace4_count", 512'(mon_n[1] - base[1]), 512'(8));
        chk("pace1_count", 512'(mon_n[0] - base[0]), 512'(8));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pace4_md%0d", k), 512'(mon_md[1][(base[1] + k) % 64]), 512'(16'h0040 + 16'(k)));
            chk($sformatf("pace4_cyc%0d", k), 512'(mon_cyc[1][(base[1] + k) % 64]), 512'(t0 + 2 + 4 * k));
            chk($sformatf("pace1_cyc%0d", k), 512'(mon_cyc[0][(base[0] + k) % 64]), 512'(t0 + 2 + k));
        end
        chk("pace4_byte", 512'(mon_b[1][(base[1] + 7) % 64]), 512'(8'h5A));
        chk("pace4_no_afull", 512'(afull_seen), 512'(0));
        chk("pace4_stat_rd", 512'(rd_cnt[1]), 512'(8));

        // Overflow: 20 reads ignoring almost-full on the interval-8 instance.
        do_reset();
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) base[i] = mon_n[i];
        for (int k = 0; k < 20; k++) begin
            set_rd(42'd7, 16'h0100 + 16'(k));
            @(negedge clk);
        end
        clr_req();
        chk("ovf_afull", 512'(rd_afull[2]), 512'(1));
        chk("ovf_err", 512'(err[2]), 512'(1));
        chk("ovf_stat_rd", 512'(rd_cnt[2]), 512'(19));
        chk("ovf_i1_err", 512'(err[0]), 512'(0));
        chk("ovf_i1_stat_rd", 512'(rd_cnt[0]), 512'(20));
        for (int w = 0; w < 300 && (mon_n[2] - base[2]) < 19; w++) @(negedge clk);
        repeat (20) @(negedge clk);
        #1;
        chk("ovf_rsp_count", 512'(mon_n[2] - base[2]), 512'(rd_cnt[2]));
        chk("ovf_rsp_19", 512'(mon_n[2] - base[2]), 512'(19));
        for (int k = 0; k < 19; k += 6) begin
            chk($sformatf("ovf_md%0d", k), 512'(mon_md[2][(base[2] + k) % 64]), 512'(16'h0100 + 16'(k)));
        end
        chk("ovf_afull_clear", 512'(rd_afull[2]), 512'(0));

        // Reset with reads in flight: no late responses, RAM survives.
        @(negedge clk);
        set_rd(42'd7, 16'h0200);
        @(negedge clk);
        set_rd(42'd7, 16'h0201);
        @(negedge clk);
        set_rd(42'd7, 16'h0202);
        @(negedge clk);
        clr_req();
        spl_reset = 1'b1;
        @(negedge clk);
        chk("rst_valids", 512'({rd_valid[0], rd_valid[1], rd_valid[2], wr_valid[0], rd_afull[2], wr_afull[2]}), 512'(0));
        chk("rst_err", 512'({err[0], err[1], err[2]}), 512'(0));
        chk("rst_cnts", 512'({rd_cnt[0], wr_cnt[0], rd_cnt[2]}), 512'(0));
        chk("rst_data", rx_data[0], 512'(0));
        #1;
        for (int i = 0; i < 3; i++) base[i] = mon_n[i];
        spl_reset = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("rst_no_rsp_i1", 512'(mon_n[0] - base[0]), 512'(0));
        chk("rst_no_rsp_i4", 512'(mon_n[1] - base[1]), 512'(0));
        chk("rst_no_rsp_i8", 512'(mon_n[2] - base[2]), 512'(0));
        @(negedge clk);
        set_rd(42'd5, 16'h0055);
        @(negedge clk);
        clr_req();
        @(negedge clk);
        chk("rst_ram_valid", 512'(rd_valid[0]), 512'(1));
        chk("rst_ram_hdr", 512'(rd_hdr[0]), 512'(exp_rd_hdr(16'h0055)));
        chk("rst_ram_data", rx_data[0], {64{8'h3C}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
